muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/muldiv_div_core.sv | 66 ++++++
 rtl/muldiv_unit.sv | 178 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types for the RV32/64 M-extension multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN_DEF = 32;

  // funct3 encodings of the M extension
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_div_core.sv
// Restoring unsigned divider, one quotient bit per cycle for XLEN cycles.
// Works on operand magnitudes; sign correction is done by the caller.
module muldiv_div_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quo_o,
  output logic [XLEN-1:0] rem_o,
  output logic            done_o
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN-1);

  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvsr_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic [XLEN:0]   rem_sh, diff;

  // One restoring step: shift in the next dividend bit, try to subtract.
  always_comb begin
    rem_sh = {rem_q, quo_q[XLEN-1]};
    diff   = rem_sh - {1'b0, dvsr_q};
    rem_d  = rem_sh[XLEN-1:0];
    quo_d  = {quo_q[XLEN-2:0], 1'b0};
    if (!diff[XLEN]) begin
      rem_d    = diff[XLEN-1:0];
      quo_d[0] = 1'b1;
    end
  end

  // Iteration state; quotient accumulates in place of the dividend.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (abort_i) begin
      busy_q <= 1'b0;
    end else if (start_i) begin
      quo_q  <= dividend_i;
      rem_q  <= '0;
      dvsr_q <= divisor_i;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_q + CW'(1);
      if (cnt_q == CNT_LAST) busy_q <= 1'b0;
    end
  end

  // High during the cycle whose closing edge performs the final step.
  assign done_o = busy_q && (cnt_q == CNT_LAST);
  assign quo_o  = quo_q;
  assign rem_o  = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// RISC-V M-extension multiply/divide unit: IDLE/BUSY/DONE FSM, operand
// sign handling, iterative shift-add multiplier, divider sub-module.
// Optional: MULDIV_SINGLE_CYCLE_MUL_EN gives multiplies a one-cycle
// combinational product instead of the iterative path.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e state_q, state_d;
  op_e    op_in, op_q;
  logic   accept, fast_in, busy_fin, div_done;

  // Request decode
  logic            a_sgn, b_sgn, a_neg, b_neg, b_zero, ovf, spec_in;
  logic [XLEN-1:0] a_mag, b_mag, spec_res_in;

  // Captured operation context
  logic            a_neg_q, b_neg_q, spec_q;
  logic [XLEN-1:0] spec_res_q;
  logic [2*XLEN-1:0] prod_q;

  logic [XLEN-1:0]   div_quo, div_rem, quo_s, rem_s;
  logic [2*XLEN-1:0] prod_s;

`ifndef MULDIV_SINGLE_CYCLE_MUL_EN
  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN-1);
  logic [2*XLEN-1:0] mcand_q;
  logic [XLEN-1:0]   mplier_q;
  logic [CW-1:0]     cnt_q;
`else
  logic [2*XLEN-1:0] prod_w;
`endif

  // Operand signedness, magnitudes and divide corner cases.
  always_comb begin
    op_in  = op_e'(funct3_i);
    a_sgn  = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
             (op_in == OP_DIV)  || (op_in == OP_REM);
    b_sgn  = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    a_neg  = a_sgn && op_a_i[XLEN-1];
    b_neg  = b_sgn && op_b_i[XLEN-1];
    a_mag  = a_neg ? -op_a_i : op_a_i;
    b_mag  = b_neg ? -op_b_i : op_b_i;
    b_zero = (op_b_i == '0);
    ovf    = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
             (op_a_i == MIN_NEG) && (op_b_i == '1);
    spec_in = funct3_i[2] && (b_zero || ovf);
    spec_res_in = '0;
    case (op_in)
      OP_DIV:  spec_res_in = b_zero ? '1 : MIN_NEG;
      OP_DIVU: spec_res_in = '1;
      OP_REM:  spec_res_in = b_zero ? op_a_i : '0;
      OP_REMU: spec_res_in = op_a_i;
      default: spec_res_in = '0;
    endcase
  end

`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
  assign prod_w   = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
  assign fast_in  = spec_in || !funct3_i[2];
  assign busy_fin = div_done;
`else
  assign fast_in  = spec_in;
  assign busy_fin = op_q[2] ? div_done : (cnt_q == CNT_LAST);
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next state and handshake outputs; flush overrides everything.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    ready_o = (state_q == S_IDLE);
    valid_o = (state_q == S_DONE);
    case (state_q)
      S_IDLE: if (valid_i && !flush_i) begin
        accept  = 1'b1;
        state_d = fast_in ? S_DONE : S_BUSY;
      end
      S_BUSY: if (busy_fin) state_d = S_DONE;
      S_DONE: if (ready_i)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  // Operation context and multiply datapath.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q       <= OP_MUL;
      a_neg_q    <= 1'b0;
      b_neg_q    <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      prod_q     <= '0;
`ifndef MULDIV_SINGLE_CYCLE_MUL_EN
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
`endif
    end else if (accept) begin
      op_q       <= op_in;
      a_neg_q    <= a_neg;
      b_neg_q    <= b_neg;
      spec_q     <= spec_in;
      spec_res_q <= spec_res_in;
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
      prod_q     <= prod_w;
`else
      prod_q     <= '0;
      mcand_q    <= {{XLEN{1'b0}}, a_mag};
      mplier_q   <= b_mag;
      cnt_q      <= '0;
`endif
    end
`ifndef MULDIV_SINGLE_CYCLE_MUL_EN
    else if (state_q == S_BUSY && !op_q[2]) begin
      if (mplier_q[0]) prod_q <= prod_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
    end
`endif
  end

  muldiv_div_core #(.XLEN(XLEN)) u_div (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (accept && funct3_i[2] && !spec_in),
    .abort_i    (flush_i),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .quo_o      (div_quo),
    .rem_o      (div_rem),
    .done_o     (div_done)
  );

  // Sign correction of magnitudes; result is forced to zero outside DONE.
  always_comb begin
    prod_s   = (a_neg_q ^ b_neg_q) ? -prod_q : prod_q;
    quo_s    = (a_neg_q ^ b_neg_q) ? -div_quo : div_quo;
    rem_s    = a_neg_q ? -div_rem : div_rem;
    result_o = '0;
    if (state_q == S_DONE) begin
      if (spec_q) result_o = spec_res_q;
      else begin
        case (op_q)
          OP_MUL:                       result_o = prod_s[XLEN-1:0];
          OP_MULH, OP_MULHSU, OP_MULHU: result_o = prod_s[2*XLEN-1:XLEN];
          OP_DIV, OP_DIVU:              result_o = quo_s;
          default:                      result_o = rem_s;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at XLEN=32.
module tb_muldiv_unit;

  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic        valid_i = 1'b0, flush_i = 1'b0, ready_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [31:0] op_a_i = '0, op_b_i = '0;
  logic        ready_o, valid_o;
  logic [31:0] result_o;

  int n_chk = 0, n_pass = 0;

`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  muldiv_unit #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .funct3_i(funct3_i), .op_a_i(op_a_i), .op_b_i(op_b_i), .flush_i(flush_i),
    .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Issue one request, wait for the result, check latency and value, retire it.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    chk({tag, ".rdy"}, 32'(ready_o), 32'd1);
    funct3_i = f3; op_a_i = a; op_b_i = b; valid_i = 1'b1;
    @(posedge clk_i); #1 valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 100) begin @(posedge clk_i); #1; lat++; end
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".res"}, result_o, exp);
    ready_i = 1'b1;
    @(posedge clk_i); #1 ready_i = 1'b0;
    chk({tag, ".ret"}, 32'(valid_o), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    // reset values while held in reset
    #12;
    chk("rst.ready", 32'(ready_o), 32'd1);
    chk("rst.valid", 32'(valid_o), 32'd0);
    chk("rst.result", result_o, 32'd0);
    @(posedge clk_i); #1 rst_ni = 1'b1;

    // first accept right on the first edge after reset release
    run_op("divu0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu0", 3'b111, 32'd5, 32'd0, 32'd5, 1);
    run_op("div0", 3'b100, 32'd9, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem0", 3'b110, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 1);

    run_op("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT);
    run_op("mul2", 3'b000, 32'h1234_5678, 32'h10, 32'h2345_6780, MUL_LAT);
    run_op("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
    run_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
    run_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);

    run_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("div.nb", 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_op("rem.nb", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    run_op("divu", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu", 3'b111, 32'd100, 32'd7, 32'd2, 33);
    run_op("div.ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem.ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // backpressure: hold the result for 10 cycles
    funct3_i = 3'b101; op_a_i = 32'd100; op_b_i = 32'd7; valid_i = 1'b1;
    @(posedge clk_i); #1 valid_i = 1'b0;
    for (int i = 0; i < 40 && !valid_o; i++) begin @(posedge clk_i); #1; end
    for (int i = 0; i < 10; i++) begin
      chk("bp.valid", 32'(valid_o), 32'd1);
      chk("bp.result", result_o, 32'd14);
      chk("bp.ready", 32'(ready_o), 32'd0);
      @(posedge clk_i); #1;
    end
    // handshake with a new request offered: must not be taken (no bypass)
    funct3_i = 3'b101; op_a_i = 32'd5; op_b_i = 32'd0; valid_i = 1'b1; ready_i = 1'b1;
    @(posedge clk_i); #1 valid_i = 1'b0; ready_i = 1'b0;
    chk("bp.idle", 32'(ready_o), 32'd1);
    chk("bp.nobypass", 32'(valid_o), 32'd0);

    // flush at BUSY cycle 5 with valid_i held high
    funct3_i = 3'b101; op_a_i = 32'd100; op_b_i = 32'd7; valid_i = 1'b1;
    @(posedge clk_i); #1;
    repeat (4) begin @(posedge clk_i); #1; end
    chk("fl.busy", 32'(ready_o), 32'd0);
    flush_i = 1'b1;
    @(posedge clk_i); #1 flush_i = 1'b0;
    chk("fl.idle", 32'(ready_o), 32'd1);
    chk("fl.valid", 32'(valid_o), 32'd0);
    // valid_i still high with flush in IDLE: flush wins, no accept
    flush_i = 1'b1;
    @(posedge clk_i); #1 flush_i = 1'b0; valid_i = 1'b0;
    chk("fl.noacc", 32'(ready_o), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i); #1;
      if (valid_o) seen = 1'b1;
    end
    chk("fl.noresult", 32'(seen), 32'd0);

    // async reset mid-BUSY
    funct3_i = 3'b101; op_a_i = 32'd100; op_b_i = 32'd7; valid_i = 1'b1;
    @(posedge clk_i); #1 valid_i = 1'b0;
    repeat (3) begin @(posedge clk_i); #1; end
    #2 rst_ni = 1'b0;
    #1 chk("rb.ready", 32'(ready_o), 32'd1);
    chk("rb.valid", 32'(valid_o), 32'd0);
    @(posedge clk_i); #1 rst_ni = 1'b1;

    // async reset while DONE holds a result
    funct3_i = 3'b101; op_a_i = 32'd5; op_b_i = 32'd0; valid_i = 1'b1;
    @(posedge clk_i); #1 valid_i = 1'b0;
    chk("rd.pre", result_o, 32'hFFFF_FFFF);
    #2 rst_ni = 1'b0;
    #1 chk("rd.valid", 32'(valid_o), 32'd0);
    chk("rd.result", result_o, 32'd0);
    chk("rd.ready", 32'(ready_o), 32'd1);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    run_op("post", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
